// File: rtl/pixel_stream_proc.sv
// pixel_stream_proc: streaming per-pixel engine (bypass/invert/threshold/gradient) with line/frame markers.
// Define PSP_FRAME_CNT_EN to add the frame_cnt output counting handshaken end-of-frame pixels.
module pixel_stream_proc #(
    parameter int PIXEL_W    = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [PIXEL_W-1:0] thresh,
    input  logic [PIXEL_W-1:0] pixel_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [PIXEL_W-1:0] pixel_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               eol_out,
    output logic               eof_out
`ifdef PSP_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [PIXEL_W-1:0] prev_q, prev_d, thr_q, thr_d, pix_q, pix_d;
    logic [1:0]         mode_q, mode_d;
    logic               valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
    logic               accept, line_start, eol, eof;
    logic [1:0]         cur_mode;
    logic [PIXEL_W-1:0] cur_thr, grad, res;

    assign ready_out = !valid_q || ready_in;
    assign valid_out = valid_q;
    assign pixel_out = pix_q;
    assign eol_out   = eol_q;
    assign eof_out   = eof_q;

    // The first pixel of a line is processed with the freshly sampled mode/thresh.
    always_comb begin
        accept     = valid_in && ready_out;
        line_start = col_q == '0;
        eol        = col_q == COL_LAST;
        eof        = eol && row_q == ROW_LAST;
        cur_mode   = line_start ? mode : mode_q;
        cur_thr    = line_start ? thresh : thr_q;
        grad       = pixel_in >= prev_q ? pixel_in - prev_q : prev_q - pixel_in;
        res        = cur_mode == 2'b00 ? pixel_in :
                     cur_mode == 2'b01 ? ~pixel_in :
                     cur_mode == 2'b10 ? (pixel_in >= cur_thr ? {PIXEL_W{1'b1}} : '0) :
                     (line_start ? '0 : grad);
        valid_d    = accept ? 1'b1 : (ready_in ? 1'b0 : valid_q);
        pix_d      = accept ? res : pix_q;
        eol_d      = accept ? eol : eol_q;
        eof_d      = accept ? eof : eof_q;
        col_d      = accept ? (eol ? '0 : col_q + CW'(1)) : col_q;
        row_d      = accept && eol ? (row_q == ROW_LAST ? '0 : row_q + RW'(1)) : row_q;
        prev_d     = accept ? pixel_in : prev_q;
        mode_d     = accept && line_start ? mode : mode_q;
        thr_d      = accept && line_start ? thresh : thr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pix_q   <= '0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            prev_q  <= '0;
            mode_q  <= 2'b00;
            thr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pix_q   <= pix_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            col_q   <= col_d;
            row_q   <= row_d;
            prev_q  <= prev_d;
            mode_q  <= mode_d;
            thr_q   <= thr_d;
        end
    end

`ifdef PSP_FRAME_CNT_EN
    logic [15:0] fc_q, fc_d;
    assign frame_cnt = fc_q;
    always_comb fc_d = valid_q && ready_in && eof_q ? fc_q + 16'd1 : fc_q;
    always_ff @(posedge clk) begin
        if (rst) fc_q <= '0;
        else fc_q <= fc_d;
    end
`endif
endmodule
